// File: rtl/fifo_level.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_level #(
    parameter int WIDTH  = 8,
    parameter int NUM    = 256,
    parameter int BITS   = $clog2(NUM),
    parameter int AFULL  = NUM - 4,
    parameter int AEMPTY = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_strobe,
    input  logic             read_strobe,
    output logic [WIDTH-1:0] read_data,
    output logic             data_available,
    output logic             space_available,
    output logic [BITS:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             werror,
    output logic             rerror
);

    logic [WIDTH-1:0] mem [NUM];

    logic [BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BITS-1:0]  rd_next;
    logic [BITS:0]    count_q, count_d;
    logic [WIDTH-1:0] read_data_q, read_data_d;
    logic             data_available_q, space_available_q;
    logic             almost_full_q, almost_empty_q;
    logic             werror_q, werror_d;
    logic             rerror_q, rerror_d;
    logic             acc_write, acc_read;

    // A write into a full FIFO is only legal when a read frees the slot this cycle.
    assign acc_read  = read_strobe & data_available_q;
    assign acc_write = write_strobe & (space_available_q | acc_read);
    assign rd_next   = rd_ptr_q + BITS'(1);

    always_comb begin
        wr_ptr_d    = wr_ptr_q + BITS'(acc_write);
        rd_ptr_d    = rd_ptr_q + BITS'(acc_read);
        count_d     = count_q + (BITS+1)'(acc_write) - (BITS+1)'(acc_read);
        werror_d    = werror_q | (write_strobe & ~acc_write);
        rerror_d    = rerror_q | (read_strobe & ~data_available_q);
        read_data_d = read_data_q;
        // Head register: bypass incoming data when it becomes the only word.
        if (acc_read) begin
            if (count_q > (BITS+1)'(1))
                read_data_d = mem[rd_next];
            else if (acc_write)
                read_data_d = write_data;
        end else if (acc_write && count_q == '0) begin
            read_data_d = write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_write)
            mem[wr_ptr_q] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            read_data_q       <= '0;
            data_available_q  <= 1'b0;
            space_available_q <= 1'b1;
            almost_full_q     <= 1'b0;
            almost_empty_q    <= 1'b1;
            werror_q          <= 1'b0;
            rerror_q          <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            read_data_q       <= read_data_d;
            data_available_q  <= (count_d != '0);
            space_available_q <= (count_d != (BITS+1)'(NUM));
            almost_full_q     <= (count_d >= (BITS+1)'(AFULL));
            almost_empty_q    <= (count_d <= (BITS+1)'(AEMPTY));
            werror_q          <= werror_d;
            rerror_q          <= rerror_d;
        end
    end

    assign read_data       = read_data_q;
    assign data_available  = data_available_q;
    assign space_available = space_available_q;
    assign count           = count_q;
    assign almost_full     = almost_full_q;
    assign almost_empty    = almost_empty_q;
    assign werror          = werror_q;
    assign rerror          = rerror_q;

endmodule
